// File: rtl/div_32.sv
// Iterative restoring divider: one quotient bit per cycle, start/ready handshake.
// Optional macro DIV_SIGNED_EN selects two's complement operands with sign correction.
module div_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CNT_W-1:0] cnt;
    logic             last, div_zero;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_nxt, quo_nxt, a_mag, b_mag, q_fix, r_fix;

    assign div_zero = (divisor == '0);
    assign last     = (cnt == CNT_W'(WIDTH-1));

    // Restoring step; the sign bit of the WIDTH+1 bit trial decides the quotient bit.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, dvs};
    assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, neg_r;

    assign a_neg = dividend[WIDTH-1];
    assign b_neg = divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign q_fix = neg_q ? -quo_nxt : quo_nxt;
    assign r_fix = neg_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (ctrl_div && !div_zero) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = quo_nxt;
    assign r_fix = rem_nxt;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A start is honoured in every state; in RUN it discards the in-flight operation.
    always_comb begin
        state_nxt = state;
        if (ctrl_div) begin
            state_nxt = div_zero ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state == RUN);
        result_rdy = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            exception <= 1'b0;
        end else if (ctrl_div) begin
            if (div_zero) begin
                quotient  <= '0;
                remainder <= dividend;
                exception <= 1'b1;
            end else begin
                rem <= '0;
                quo <= a_mag;
                dvs <= b_mag;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            // Results land on the edge into DONE so they are valid with result_rdy.
            if (last) begin
                quotient  <= q_fix;
                remainder <= r_fix;
                exception <= 1'b0;
            end
        end
    end

endmodule

// File: doc/div_32.md
Name: div_32

Overview:
- Iterative 32-bit restoring divider for the multi-cycle execute path of the 5-stage pipeline.
- The ALU multiply path builds results up from partial products; this block runs the inverse operation and decomposes a dividend into quotient and remainder, one bit per cycle.
- Uses a start/ready handshake. The pipeline stalls on busy and resumes when result_rdy fires.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- ctrl_div  input  1  start pulse; operands are sampled on the edge where it is high.
- dividend  input  WIDTH  operand A, sampled only with ctrl_div.
- divisor  input  WIDTH  operand B, sampled only with ctrl_div.
- quotient  output  WIDTH  result quotient; held until the next start.
- remainder  output  WIDTH  result remainder; held until the next start.
- result_rdy  output  1  one-cycle pulse when quotient/remainder/exception are valid.
- exception  output  1  divide-by-zero flag; valid with result_rdy, held until the next start.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset: state=IDLE, quotient=0, remainder=0, result_rdy=0, exception=0, busy=0, counter=0. Reset wins over ctrl_div in the same cycle. Reset mid-operation aborts with no result_rdy.
- States: IDLE, RUN, DONE.
- IDLE, ctrl_div=1, divisor!=0:
  - Latch the operand magnitudes.
  - Clear the partial remainder; counter=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, ctrl_div=1, divisor==0:
  - Go to DONE; quotient=0, remainder=dividend, exception=1.
  - result_rdy high exactly 1 cycle after the start edge.
- RUN, each cycle:
  - Shift {rem,quo} left by 1; trial = rem - divisor_mag (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
  - Counter increments. After WIDTH iterations (counter==WIDTH-1) go to DONE.
- DONE:
  - Apply sign correction, drive the outputs, result_rdy=1 for this single cycle, busy=0.
  - Return to IDLE.
- Latency: ctrl_div high in cycle 0 -> result_rdy high in cycle WIDTH+1 (cycle 33 for the default).
- ctrl_div while busy (RUN): the in-flight operation is discarded; new operands are latched and counting restarts at 0. No result_rdy is issued for the aborted operation.
- ctrl_div in the DONE cycle: the result pulse still issues; the new operation starts as if from IDLE.
- Outputs change only in DONE. Between operations quotient/remainder/exception hold their last values.
- Without DIV_SIGNED_EN: operands are unsigned, no sign correction.

Optional Feature:
DIV_SIGNED_EN
- Defined:
  - Operands are two's complement; the datapath iterates on absolute values.
  - Quotient is negated when the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Overflow case -2^31 / -1 gives quotient=0x80000000, remainder=0, exception=0, normal latency.
- Undefined: pure unsigned divide, no negation logic present.

Test Plan:
- Unsigned 100 / 7, ctrl_div 1 cycle -> result_rdy only at cycle 33, quotient=14, remainder=2, exception=0, busy high cycles 1-32.
- 0xFFFFFFFF / 1 unsigned -> quotient=0xFFFFFFFF, remainder=0. With DIV_SIGNED_EN, -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Divisor 0, dividend 5 -> result_rdy at cycle 1, exception=1, quotient=0, remainder=5. A following 10 / 3 clears exception: quotient=3, remainder=1.
- Start 100 / 7, re-pulse ctrl_div at cycle 10 with 50 / 5 -> single result_rdy at cycle 43, quotient=10, remainder=0. No pulse at cycle 33.
- Start an operation, assert reset at cycle 15 -> busy=0 and outputs=0 the next cycle; no result_rdy ever fires. Reset together with ctrl_div -> stays IDLE.
- With DIV_SIGNED_EN, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, exception=0 at cycle 33.
